alu_issue_buffer: RTL and testbench



---
 rtl/alu_issue_buffer.sv | 154 +++++++++++++++
 tb/tb_alu_issue_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_buffer
//  Description : Two-entry valid/ready skid buffer in front of the 64-bit ALU
//                logic units. Registers opcode and both operands so the ALU is
//                fed from flops, absorbs one cycle of backpressure, and keeps
//                in_ready a pure function of the state register.
//                Optional performance counters: define ALU_ISSUE_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_buffer #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   out_op,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]      perf_accepted,
    output logic [31:0]      perf_stalls
`endif
);

    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_one   = 2'd1;
    localparam logic [1:0] c_full  = 2'd2;

    logic [1:0]       r_state;
    logic [OPW-1:0]   r_main_op;
    logic [WIDTH-1:0] r_main_a;
    logic [WIDTH-1:0] r_main_b;
    logic [OPW-1:0]   r_skid_op;
    logic [WIDTH-1:0] r_skid_a;
    logic [WIDTH-1:0] r_skid_b;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // Handshake flags are derived from the state register only, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready   = (r_state != c_full);
    assign out_valid  = (r_state != c_empty);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    assign out_op = r_main_op;
    assign out_a  = r_main_a;
    assign out_b  = r_main_b;

    // Data-path load enables; a flush suppresses every load so a
    // same-cycle input is dropped.
    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (!flush) begin
            case (r_state)
                c_empty: w_load_main_in   = w_in_fire;
                c_one: begin
                    w_load_main_in = w_in_fire & w_out_fire;
                    w_load_skid    = w_in_fire & ~w_out_fire;
                end
                c_full:  w_load_main_skid = w_out_fire;
                default: ;
            endcase
        end
    end

    // Occupancy state machine: reset beats flush beats handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_empty;
        end else if (flush) begin
            r_state <= c_empty;
        end else begin
            case (r_state)
                c_empty: if (w_in_fire) r_state <= c_one;
                c_one: begin
                    if (w_in_fire && !w_out_fire)      r_state <= c_full;
                    else if (!w_in_fire && w_out_fire) r_state <= c_empty;
                end
                c_full:  if (w_out_fire) r_state <= c_one;
                default: r_state <= c_empty;
            endcase
        end
    end

    // Main register: fed from the input when streaming/empty, from the skid
    // when draining a full buffer; otherwise held stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_op <= '0;
            r_main_a  <= '0;
            r_main_b  <= '0;
        end else if (w_load_main_in) begin
            r_main_op <= in_op;
            r_main_a  <= in_a;
            r_main_b  <= in_b;
        end else if (w_load_main_skid) begin
            r_main_op <= r_skid_op;
            r_main_a  <= r_skid_a;
            r_main_b  <= r_skid_b;
        end
    end

    // Skid register captures the entry that arrives while main is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_op <= '0;
            r_skid_a  <= '0;
            r_skid_b  <= '0;
        end else if (w_load_skid) begin
            r_skid_op <= in_op;
            r_skid_a  <= in_a;
            r_skid_b  <= in_b;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] r_perf_accepted;
    logic [31:0] r_perf_stalls;

    assign perf_accepted = r_perf_accepted;
    assign perf_stalls   = r_perf_stalls;

    // Free-running wrap-around counters; flush does not clear them and
    // handshakes in a flush cycle still count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_accepted <= '0;
            r_perf_stalls   <= '0;
        end else begin
            if (w_in_fire)               r_perf_accepted <= r_perf_accepted + 32'd1;
            if (out_valid && !out_ready) r_perf_stalls   <= r_perf_stalls + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_buffer
//  Description : Self-checking bench for alu_issue_buffer. A queue model of
//                the two-entry FIFO is compared every cycle; directed
//                sequences add hand-computed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_buffer;

    localparam int WIDTH = 64;
    localparam int OPW   = 4;

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [OPW-1:0]   out_op;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0]      perf_accepted;
    logic [31:0]      perf_stalls;
`endif

    alu_issue_buffer #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_a     (out_a),
        .out_b     (out_b)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_accepted (perf_accepted),
        .perf_stalls   (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t        q[$];
    bit          model_live = 0;
    bit          zero_data  = 0;   // data outputs must read zero since reset
    logic [31:0] m_acc = 0;
    logic [31:0] m_stl = 0;

    // Model update: a FIFO of at most two entries, evaluated on the pre-edge inputs.
    always @(posedge clk) begin
        int  sz;
        bit  infire;
        bit  outfire;
        ent_t e;
        sz      = q.size();
        infire  = in_valid && (sz < 2);
        outfire = (sz > 0) && out_ready;
        e.op = in_op; e.a = in_a; e.b = in_b;
        if (rst) begin
            q.delete();
            zero_data = 1;
            m_acc = 0;
            m_stl = 0;
        end else begin
            if (infire)                 m_acc = m_acc + 32'd1;
            if (sz > 0 && !out_ready)   m_stl = m_stl + 32'd1;
            if (flush) begin
                q.delete();
            end else begin
                if (outfire) void'(q.pop_front());
                if (infire) begin
                    q.push_back(e);
                    zero_data = 0;
                end
            end
        end
        model_live = 1;
    end

    // Per-cycle comparison, on the falling edge away from the active edge.
    int fire_cnt  = 0;
    bit count_win = 0;
    always @(negedge clk) begin
        if (model_live) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
            chk("in_ready",  {63'd0, in_ready},  {63'd0, q.size() < 2});
            if (q.size() != 0) begin
                chk("out_op", {60'd0, out_op}, {60'd0, q[0].op});
                chk("out_a",  out_a, q[0].a);
                chk("out_b",  out_b, q[0].b);
            end else if (zero_data) begin
                chk("out_op_zero", {60'd0, out_op}, 64'd0);
                chk("out_a_zero",  out_a, 64'd0);
                chk("out_b_zero",  out_b, 64'd0);
            end
`ifdef ALU_ISSUE_PERF_EN
            chk("perf_accepted", {32'd0, perf_accepted}, {32'd0, m_acc});
            chk("perf_stalls",   {32'd0, perf_stalls},   {32'd0, m_stl});
`endif
            if (count_win && out_valid && out_ready) fire_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [OPW-1:0] op);
        in_valid = v; in_a = a; in_b = b; in_op = op;
    endtask

    initial begin
        rst = 1; flush = 0; out_ready = 0;
        drive(1, 64'h55, 64'h66, 4'h7);

        // Reset held two cycles with in_valid high: nothing captured.
        step(); step();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_a",     out_a, 64'd0);
        chk("rst_out_b",     out_b, 64'd0);
        chk("rst_out_op",    {60'd0, out_op}, 64'd0);
        rst = 0;
        drive(0, 0, 0, 0);
        step();
        chk("rst_no_capture", {63'd0, out_valid}, 64'd0);

        // Streaming: one transfer per clock, one-cycle latency.
        out_ready = 1;
        count_win = 1;
        for (int i = 1; i <= 8; i++) begin
            logic [WIDTH-1:0] iv;
            iv = WIDTH'(i);
            drive(1, iv, ~iv, iv[OPW-1:0]);
            step();
            chk("stream_a",     out_a, iv);
            chk("stream_b",     out_b, ~iv);
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
        end
        drive(0, 0, 0, 0);
        step(); step();
        count_win = 0;
        chk("stream_fires", 64'(fire_cnt), 64'd8);
        chk("stream_drained", {63'd0, out_valid}, 64'd0);

        // Backpressure: two accepts fill the buffer, then drain in order.
        out_ready = 0;
        drive(1, 64'hA, 64'h1A, 4'h1); step();
        drive(1, 64'hB, 64'h1B, 4'h2); step();
        drive(0, 0, 0, 0);
        chk("bp_model_full", 64'(q.size()), 64'd2);
        chk("bp_in_ready",   {63'd0, in_ready}, 64'd0);
        chk("bp_hold_a",     out_a, 64'hA);
        step();
        chk("bp_still_a",    out_a, 64'hA);
        out_ready = 1;
        chk("bp_first_a",    out_a, 64'hA);
        step();
        chk("bp_second_a",   out_a, 64'hB);
        chk("bp_second_op",  {60'd0, out_op}, 64'd2);
        step();
        chk("bp_empty",      {63'd0, out_valid}, 64'd0);

        // Simultaneous accept and drain while holding one entry.
        drive(1, 64'h1, 64'h0, 4'h0); step();
        drive(1, 64'h2, 64'h0, 4'h0); step();
        chk("sim_out_a",    out_a, 64'h2);
        chk("sim_in_ready", {63'd0, in_ready}, 64'd1);
        drive(0, 0, 0, 0); step();
        chk("sim_empty",    {63'd0, out_valid}, 64'd0);

        // Flush from FULL with a concurrent input: everything dropped.
        out_ready = 0;
        drive(1, 64'hA, 0, 0); step();
        drive(1, 64'hB, 0, 0); step();
        flush = 1;
        drive(1, 64'hC, 0, 0); step();
        flush = 0;
        drive(0, 0, 0, 0);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready",  {63'd0, in_ready},  64'd1);
        out_ready = 1;
        step(); step();
        chk("flush_no_c", {63'd0, out_valid}, 64'd0);

        // Mixed traffic with toggling valid/ready; model checks each cycle.
        begin
            logic [15:0] vpat;
            logic [15:0] rpat;
            vpat = 16'b1011_0111_1100_1101;
            rpat = 16'b0110_0011_1011_0010;
            for (int i = 0; i < 16; i++) begin
                drive(vpat[i], 64'hF000 + 64'(i), 64'hDEAD_0000 + 64'(i), OPW'(i));
                out_ready = rpat[i];
                step();
            end
            drive(0, 0, 0, 0);
            out_ready = 1;
            step(); step(); step();
            chk("mix_drained", {63'd0, out_valid}, 64'd0);
        end

        // Reset wins over flush and a pending input.
        out_ready = 0;
        drive(1, 64'h77, 0, 0); step();
        rst = 1; flush = 1; drive(1, 64'h88, 0, 0); step();
        rst = 0; flush = 0; drive(0, 0, 0, 0);
        chk("rst_prio_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_prio_a",     out_a, 64'd0);

`ifdef ALU_ISSUE_PERF_EN
        // 5 accepts with 3 stall cycles after a fresh reset.
        rst = 1; step(); rst = 0;
        out_ready = 1;
        drive(1, 64'h1, 0, 0); step();
        drive(1, 64'h2, 0, 0); step();
        drive(1, 64'h3, 0, 0); step();
        drive(0, 0, 0, 0); out_ready = 0; step();
        step();
        drive(1, 64'h4, 0, 0); step();
        drive(0, 0, 0, 0); out_ready = 1; step();
        drive(1, 64'h5, 0, 0); step();
        drive(0, 0, 0, 0); step(); step();
        chk("perf_acc_5",   {32'd0, perf_accepted}, 64'd5);
        chk("perf_stall_3", {32'd0, perf_stalls},   64'd3);

        // Wrap: preload the accept counter to all-ones, then one accept.
        force dut.r_perf_accepted = 32'hFFFF_FFFF;
        #1;
        release dut.r_perf_accepted;
        m_acc = 32'hFFFF_FFFF;
        drive(1, 64'h9, 0, 0); step();
        drive(0, 0, 0, 0);
        chk("perf_wrap", {32'd0, perf_accepted}, 64'd0);
        step(); step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
